// File: rtl/rf_sched_pkg.sv
// rtl/rf_sched_pkg.sv - shared types and constants for the RF detector scan scheduler
// Holds the scheduler state encoding, the reader detector select codes and a
// helper that maps a 0-based detector index onto its select code.
package rf_sched_pkg;

  localparam int NUM_DET = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_GAP
  } state_t;

  localparam logic [2:0] DET_NONE = 3'd0;
  localparam logic [2:0] DET1     = 3'd1;
  localparam logic [2:0] DET2     = 3'd2;
  localparam logic [2:0] DET3     = 3'd3;
  localparam logic [2:0] DET4     = 3'd4;

  function automatic logic [2:0] det_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    det_sel = DET1;
      2'd1:    det_sel = DET2;
      2'd2:    det_sel = DET3;
      default: det_sel = DET4;
    endcase
  endfunction

endpackage

// File: rtl/rf_next_det.sv
// rtl/rf_next_det.sv - finds the next set bit of a detector mask above an index
// Ports:
//   mask_i  : 4-bit detector mask
//   idx_i   : signed start index; 3'b111 (-1) searches from bit 0
//   nxt_o   : index of the lowest set bit strictly above idx_i
//   found_o : high when such a bit exists
module rf_next_det
  import rf_sched_pkg::*;
(
  input  logic [3:0] mask_i,
  input  logic [2:0] idx_i,
  output logic [1:0] nxt_o,
  output logic       found_o
);

  always_comb begin
    nxt_o   = 2'd0;
    found_o = 1'b0;
    // Walk downwards so the lowest qualifying bit is the last one written.
    for (int i = NUM_DET - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'($signed(idx_i)))) begin
        found_o = 1'b1;
        nxt_o   = i[1:0];
      end
    end
  end

endmodule

// File: rtl/rf_scan_scheduler.sv
// rtl/rf_scan_scheduler.sv - shares one RF power reader across four detectors
// Scans the enabled detectors in repeating passes, latching each dBm result,
// flagging threshold alarms and sticky per-detector timeouts.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable, det_mask      : run control and detector enables (captured per pass)
//   thresh                : signed alarm threshold, sampled when a result is stored
//   err_clr               : clears timeout_err
//   rdr_start/rdr_sel     : start pulse and detector code to the reader
//   rdr_done/rdr_power    : reader completion and signed result
//   pwr, valid, alarm     : per-detector stored results and status
//   timeout_err           : sticky per-detector timeout flags
//   scan_done, busy       : end-of-pass pulse, non-idle indicator
module rf_scan_scheduler
  import rf_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SCAN_GAP       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [3:0]  det_mask,
  input  logic [7:0]  thresh,
  input  logic        err_clr,
  output logic        rdr_start,
  output logic [2:0]  rdr_sel,
  input  logic        rdr_done,
  input  logic [7:0]  rdr_power,
  output logic [31:0] pwr,
  output logic [3:0]  valid,
  output logic [3:0]  alarm,
  output logic [3:0]  timeout_err,
  output logic        scan_done,
  output logic        busy
);

  // One counter serves both the WAIT timeout and the inter-pass gap.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SCAN_GAP) ? TIMEOUT_CYCLES : SCAN_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t      state_q, state_d;
  logic [1:0]  cur_q, cur_d;
  logic [3:0]  pass_mask_q, pass_mask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        rdr_start_q, rdr_start_d;
  logic [2:0]  rdr_sel_q, rdr_sel_d;
  logic [31:0] pwr_q, pwr_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  alarm_q, alarm_d;
  logic [3:0]  terr_q, terr_d;
  logic        scan_done_q, scan_done_d;
  logic        busy_q, busy_d;

  logic [1:0]  first_idx, next_idx;
  logic        first_found, next_found;

  rf_next_det u_first (
    .mask_i  (det_mask),
    .idx_i   (3'b111),
    .nxt_o   (first_idx),
    .found_o (first_found)
  );

  rf_next_det u_next (
    .mask_i  (pass_mask_q),
    .idx_i   ({1'b0, cur_q}),
    .nxt_o   (next_idx),
    .found_o (next_found)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pass_mask_d = pass_mask_q;
    cnt_d       = cnt_q;
    pwr_d       = pwr_q;
    valid_d     = valid_q;
    alarm_d     = alarm_q;
    // Clear first so a timeout raised in the same cycle still lands.
    terr_d      = err_clr ? 4'b0000 : terr_q;
    scan_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && first_found) begin
          pass_mask_d = det_mask;
          cur_d       = first_idx;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rdr_done) begin
          pwr_d[{cur_q, 3'b000} +: 8] = rdr_power;
          valid_d[cur_q]              = 1'b1;
          alarm_d[cur_q]              = $signed(rdr_power) > $signed(thresh);
          state_d                     = ST_NEXT;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          terr_d[cur_q] = 1'b1;
          state_d       = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_NEXT: begin
        cnt_d = '0;
        if (!next_found) begin
          scan_done_d = 1'b1;
          state_d     = ST_GAP;
        end else if (enable) begin
          cur_d   = next_idx;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q == CW'(SCAN_GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reader-facing outputs are registered from the next state so that
    // rdr_start and rdr_sel move together on the entry edge of ISSUE.
    rdr_start_d = (state_d == ST_ISSUE);
    rdr_sel_d   = ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) ? det_sel(cur_d) : DET_NONE;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= 2'd0;
      pass_mask_q <= 4'd0;
      cnt_q       <= '0;
      rdr_start_q <= 1'b0;
      rdr_sel_q   <= DET_NONE;
      pwr_q       <= 32'd0;
      valid_q     <= 4'd0;
      alarm_q     <= 4'd0;
      terr_q      <= 4'd0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pass_mask_q <= pass_mask_d;
      cnt_q       <= cnt_d;
      rdr_start_q <= rdr_start_d;
      rdr_sel_q   <= rdr_sel_d;
      pwr_q       <= pwr_d;
      valid_q     <= valid_d;
      alarm_q     <= alarm_d;
      terr_q      <= terr_d;
      scan_done_q <= scan_done_d;
      busy_q      <= busy_d;
    end
  end

  assign rdr_start   = rdr_start_q;
  assign rdr_sel     = rdr_sel_q;
  assign pwr         = pwr_q;
  assign valid       = valid_q;
  assign alarm       = alarm_q;
  assign timeout_err = terr_q;
  assign scan_done   = scan_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rf_scan_scheduler.sv
// tb/tb_rf_scan_scheduler.sv - self-checking bench for rf_scan_scheduler
module tb_rf_scan_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  det_mask;
  logic [7:0]  thresh;
  logic        err_clr;
  logic        rdr_start;
  logic [2:0]  rdr_sel;
  logic        rdr_done;
  logic [7:0]  rdr_power;
  logic [31:0] pwr;
  logic [3:0]  valid;
  logic [3:0]  alarm;
  logic [3:0]  timeout_err;
  logic        scan_done;
  logic        busy;

  rf_scan_scheduler #(.TIMEOUT_CYCLES(8), .SCAN_GAP(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .det_mask    (det_mask),
    .thresh      (thresh),
    .err_clr     (err_clr),
    .rdr_start   (rdr_start),
    .rdr_sel     (rdr_sel),
    .rdr_done    (rdr_done),
    .rdr_power   (rdr_power),
    .pwr         (pwr),
    .valid       (valid),
    .alarm       (alarm),
    .timeout_err (timeout_err),
    .scan_done   (scan_done),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reader model configuration (written by the main sequence only).
  int          rsp_delay;
  logic [3:0]  rsp_answer;
  logic [31:0] rsp_res;

  // Monitor state (written by the monitor only).
  int          cyc;
  int          n_start;
  int          n_done;
  int          last_done_cyc;
  int          start_cyc[$];
  logic [2:0]  sel_log[$];
  int          cd;
  logic [2:0]  cur_sel;

  int checks;
  int errors;

  // Monitor and reader: observe at the falling edge, answer rsp_delay
  // cycles after each start with a one-cycle done.
  initial begin
    cyc = 0; n_start = 0; n_done = 0; last_done_cyc = 0; cd = 0; cur_sel = 3'd0;
    rdr_done = 1'b0; rdr_power = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (scan_done) begin
        n_done++;
        last_done_cyc = cyc;
      end
      rdr_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && cur_sel >= 3'd1 && cur_sel <= 3'd4) begin
          if (rsp_answer[int'(cur_sel) - 1]) begin
            rdr_done  = 1'b1;
            rdr_power = rsp_res[8*(int'(cur_sel) - 1) +: 8];
          end
        end
      end
      if (rdr_start) begin
        cd      = rsp_delay;
        cur_sel = rdr_sel;
        sel_log.push_back(rdr_sel);
        start_cyc.push_back(cyc);
        n_start++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n   = 1'b0;
    enable  = 1'b0;
    err_clr = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_scan(input string name, input int nd0, input int budget);
    for (int k = 0; k < budget && n_done == nd0; k++) step();
    chk(name, 32'(n_done - nd0), 32'd1);
  endtask

  task automatic wait_start(input string name, input int s0, input int budget);
    for (int k = 0; k < budget && n_start == s0; k++) step();
    chk(name, 32'(n_start > s0), 32'd1);
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [7:0]  thresh;
    logic [3:0]  answer;
    logic [31:0] res;
    logic [31:0] exp_pwr;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_alarm;
    logic [3:0]  exp_terr;
    logic [15:0] exp_sels;
    int          exp_n;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int s0, nd0, t, rel;
    checks = 0; errors = 0;
    rst_n = 1'b0; enable = 1'b0; det_mask = 4'h0; thresh = 8'h00; err_clr = 1'b0;
    rsp_delay = 2; rsp_answer = 4'h0; rsp_res = 32'h0;

    //            mask   thr    ans    results        pwr            vld    alm    terr   sels      n
    vecs[0] = '{4'hF, 8'h25, 4'hF, 32'h40302010, 32'h40302010, 4'hF, 4'hC, 4'h0, 16'h4321, 4};
    vecs[1] = '{4'hA, 8'h00, 4'hF, 32'h0500F800, 32'h0500F800, 4'hA, 4'h8, 4'h0, 16'h0042, 2};
    vecs[2] = '{4'hC, 8'h80, 4'h8, 32'h81770000, 32'h81000000, 4'h8, 4'h8, 4'h4, 16'h0043, 2};
    vecs[3] = '{4'h3, 8'hF0, 4'hF, 32'h0000F1F0, 32'h0000F1F0, 4'h3, 4'h2, 4'h0, 16'h0021, 2};

    step(); step();
    chk("rst_rdr_start", 32'(rdr_start), 32'd0);
    chk("rst_rdr_sel", 32'(rdr_sel), 32'd0);
    chk("rst_pwr", pwr, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_reset();
      det_mask = vecs[i].mask; thresh = vecs[i].thresh;
      rsp_delay = 2; rsp_answer = vecs[i].answer; rsp_res = vecs[i].res;
      s0 = n_start; nd0 = n_done;
      enable = 1'b1;
      wait_scan($sformatf("v%0d_scan_done", i), nd0, 300);
      enable = 1'b0;
      chk($sformatf("v%0d_pwr", i), pwr, vecs[i].exp_pwr);
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_alarm", i), 32'(alarm), 32'(vecs[i].exp_alarm));
      chk($sformatf("v%0d_terr", i), 32'(timeout_err), 32'(vecs[i].exp_terr));
      chk($sformatf("v%0d_nstart", i), 32'(n_start - s0), 32'(vecs[i].exp_n));
      for (int j = 0; j < vecs[i].exp_n && (s0 + j) < n_start; j++)
        chk($sformatf("v%0d_sel%0d", i, j), 32'(sel_log[s0 + j]), 32'(vecs[i].exp_sels[4*j +: 4]));
    end

    // Gap: next start 17 cycles after the scan_done pulse.
    do_reset();
    det_mask = 4'hF; thresh = 8'h00; rsp_delay = 2; rsp_answer = 4'hF; rsp_res = 32'h40302010;
    nd0 = n_done;
    enable = 1'b1;
    wait_scan("gap_scan_done", nd0, 300);
    s0 = n_start;
    wait_start("gap_start_seen", s0, 40);
    if (n_start > s0) chk("gap_latency", 32'(start_cyc[s0] - last_done_cyc), 32'd17);
    chk("gap_pulse_count", 32'(n_done - nd0), 32'd1);
    enable = 1'b0;

    // Timeout on DET3, then err_clr.
    do_reset();
    det_mask = 4'b0100; rsp_delay = 2; rsp_answer = 4'h0; rsp_res = 32'h00AA0000;
    s0 = n_start;
    enable = 1'b1;
    wait_start("to_start_seen", s0, 20);
    for (int k = 0; k < 30 && timeout_err == 4'h0; k++) step();
    t = cyc;
    chk("to_terr", 32'(timeout_err), 32'h4);
    if (n_start > s0) chk("to_latency", 32'(t - start_cyc[s0]), 32'd9);
    chk("to_pwr", pwr, 32'd0);
    chk("to_valid", 32'(valid), 32'd0);
    enable = 1'b0;
    step(); step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(timeout_err), 32'd0);

    // Done on the exact timeout cycle wins.
    do_reset();
    det_mask = 4'b0001; thresh = 8'h00; rsp_delay = 8; rsp_answer = 4'h1; rsp_res = 32'h0000005A;
    nd0 = n_done;
    enable = 1'b1;
    wait_scan("edge_scan_done", nd0, 100);
    enable = 1'b0;
    chk("edge_terr", 32'(timeout_err), 32'd0);
    chk("edge_pwr", pwr, 32'h0000005A);
    chk("edge_valid", 32'(valid), 32'h1);
    chk("edge_alarm", 32'(alarm), 32'h1);

    // enable drops during WAIT on DET1.
    do_reset();
    det_mask = 4'hF; rsp_delay = 2; rsp_answer = 4'hF; rsp_res = 32'h40302010;
    s0 = n_start; nd0 = n_done;
    enable = 1'b1;
    wait_start("drop_start_seen", s0, 20);
    step();
    enable = 1'b0;
    repeat (30) step();
    chk("drop_nstart", 32'(n_start - s0), 32'd1);
    chk("drop_no_scan_done", 32'(n_done - nd0), 32'd0);
    chk("drop_pwr", pwr, 32'h00000010);
    chk("drop_valid", 32'(valid), 32'h1);
    chk("drop_busy", 32'(busy), 32'd0);

    // Reset during WAIT, then restart.
    s0 = n_start;
    enable = 1'b1;
    wait_start("rst_wait_start_seen", s0, 20);
    step();
    rst_n = 1'b0;
    #1;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_rdr_sel", 32'(rdr_sel), 32'd0);
    chk("rstw_rdr_start", 32'(rdr_start), 32'd0);
    chk("rstw_pwr", pwr, 32'd0);
    chk("rstw_valid", 32'(valid), 32'd0);
    step();
    rst_n = 1'b1;
    rel = cyc;
    s0 = n_start;
    wait_start("rstw_restart_seen", s0, 20);
    if (n_start > s0) begin
      chk("rstw_restart_lat", 32'(start_cyc[s0] - rel), 32'd1);
      chk("rstw_restart_sel", 32'(sel_log[s0]), 32'd1);
    end
    enable = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_scan_scheduler.md
# rf_scan_scheduler

Sequencer that shares the single RF power-detector reader between the four detectors (DET1–DET4). It scans the enabled detectors in a repeating pass. For each detector it issues a start with the detector select code, waits for the reader's done or a timeout, and latches the 8-bit dBm result. It also flags threshold alarms and sticky timeout errors, and sits between the reader and the host-facing register block.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles allowed before a conversion is abandoned.
- SCAN_GAP, 16: idle cycles between the end of one pass and the start of the next.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run scanning while high.
- det_mask  in  4  bit i enables detector i+1.
- thresh  in  8  signed dBm alarm threshold.
- err_clr  in  1  one-cycle pulse that clears timeout_err.
- rdr_start  out  1  one-cycle start pulse to the reader.
- rdr_sel  out  3  detector code: 3'd1–3'd4 for DET1–DET4; 3'd0 when idle.
- rdr_done  in  1  reader conversion complete; level, sampled in WAIT only.
- rdr_power  in  8  signed dBm result; valid while rdr_done=1.
- pwr  out  32  latched results {DET4,DET3,DET2,DET1}, 8 bits each.
- valid  out  4  bit i is set once detector i+1 has a stored result.
- alarm  out  4  bit i: last stored DET(i+1) result > thresh (signed).
- timeout_err  out  4  sticky per-detector timeout flags.
- scan_done  out  1  one-cycle pulse at the end of each complete pass.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, GAP.
- IDLE: rdr_sel=0. When enable=1 and det_mask≠0:
  - capture det_mask into pass_mask;
  - set cur to the lowest set bit;
  - go to ISSUE.
- ISSUE (1 cycle): rdr_start=1, rdr_sel=cur+1, clear the timeout counter, go to WAIT.
- WAIT: rdr_sel is held.
  - rdr_done=1: pwr[cur]←rdr_power, valid[cur]←1, alarm[cur]←($signed(rdr_power) > $signed(thresh)); go to NEXT.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES−1 with no done: timeout_err[cur]←1; pwr, valid and alarm are unchanged; go to NEXT.
  - rdr_done and timeout in the same cycle: done wins, and no error is set.
- NEXT (1 cycle): select the next set bit of pass_mask above cur.
  - If one exists and enable=1: go to ISSUE.
  - If none: pulse scan_done and go to GAP.
  - If enable=0: go to IDLE with no scan_done.
- GAP: count SCAN_GAP cycles, then go to IDLE, which re-captures det_mask.
- A det_mask change mid-pass takes effect from the next pass only.
- thresh is sampled at store time. Alarms are not re-evaluated when thresh changes.
- err_clr clears all timeout_err bits. If a timeout is set in the same cycle as err_clr, the set wins.
- Deasserting enable never aborts an in-flight conversion; WAIT always completes.

## Timing
- Reset values: rdr_start=0, rdr_sel=0, pwr=0, valid=0, alarm=0, timeout_err=0, scan_done=0, busy=0, state=IDLE.
- Assertion of rst_n mid-conversion returns to IDLE immediately, and the reader sees rdr_start=0.
- All outputs are registered. rdr_start and rdr_sel change on the same edge.
- Issue latency:
  - IDLE→ISSUE takes 1 cycle after enable is sampled high, so rdr_start is high in cycle 2.
- Done-to-store latency:
  - rdr_done sampled high in cycle N means pwr, valid and alarm are visible in N+1.
  - The next rdr_start is in N+2.
- Timeout: error visible TIMEOUT_CYCLES+1 cycles after the rdr_start cycle.
- Minimum per-detector slot is 3 cycles (ISSUE, WAIT with immediate done, NEXT).
- Pass period with immediate dones is 3·k + SCAN_GAP + 1 cycles for k enabled detectors.

## Structure
- Package rf_sched_pkg holds:
  - state_t enum;
  - DET_SEL codes (DET1=3'd1 … DET4=3'd4);
  - NUM_DET=4.
- Sub-module rf_next_det: a combinational finder of the next set bit of a 4-bit mask above a given index, with a found flag.
  - It is instantiated once for NEXT and once (from index −1) for IDLE.

## Test plan
- det_mask=4'b1111, reader answers 2 cycles after start with 8'h10, 8'h20, 8'h30, 8'h40 → rdr_sel sequence 1,2,3,4; pwr=32'h40302010; valid=4'hF; one scan_done; next rdr_start 17 cycles after scan_done.
- det_mask=4'b1010, thresh=8'sd0, results DET2=8'hF8 (−8), DET4=8'h05 → only rdr_sel 2 and 4 issued; alarm=4'b1000.
- TIMEOUT_CYCLES=8, DET3 never answers → timeout_err=4'b0100 after 9 cycles of waiting; pwr[DET3] unchanged; scan moves on to DET4; err_clr then clears it.
- rdr_done on the exact timeout cycle → result stored and timeout_err stays 0.
- enable drops during WAIT on DET1 with mask 4'hF → DET1 is stored, then IDLE with no scan_done and no further rdr_start.
- rst_n low during WAIT → all outputs return to reset values on the same edge; after release with enable=1, the first rdr_start is 2 cycles later with rdr_sel=1.
